// File: rtl/demux8_pkg.sv
// Shared definitions for the 8-channel TDM demultiplexer: channel geometry,
// FSM state encoding and the channel bit-offset helper.
package demux8_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bit offset of channel k inside a packed frame of w-bit samples.
    function automatic int unsigned ch_slice(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/tdm_chan_counter.sv
// Slot counter for the TDM demultiplexer: loads 1 on an accepted sync beat,
// increments on ordinary locked beats and wraps naturally modulo 8.
module tdm_chan_counter
    import demux8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    output logic [CH_W-1:0] cur_ch,
    output logic            last_slot
);

    logic [CH_W-1:0] cnt_r;

    // Slot register; a sync beat is itself channel 0, so the next slot is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CH_W{1'b0}};
        end else if (load) begin
            cnt_r <= CH_W'(1);
        end else if (inc) begin
            cnt_r <= cnt_r + CH_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cur_ch    = cnt_r;
    assign last_slot = (cnt_r == CH_W'(NUM_CH - 1));

endmodule

// File: rtl/demux_8_tdm.sv
// 8-channel TDM demultiplexer: locks to a frame-sync marker, collects samples
// in a shadow buffer and presents each complete frame atomically on dout.
module demux_8_tdm
    import demux8_pkg::*;
#(
    parameter int W     = 1,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        din,
    input  logic                din_valid,
    input  logic                din_sync,
    output logic [NUM_CH*W-1:0] dout,
    output logic                frame_valid,
    output logic                locked,
    output logic [CH_W-1:0]     cur_ch,
    output logic                sync_err,
    output logic [ERR_W-1:0]    err_count
);

    state_t              state_r;
    state_t              next_state_s;
    logic                cnt_load_s;
    logic                cnt_inc_s;
    logic                wr_en_s;
    logic [CH_W-1:0]     wr_idx_s;
    logic                frame_load_s;
    logic                err_s;
    logic [CH_W-1:0]     cur_ch_s;
    logic                last_slot_s;
    logic [NUM_CH*W-1:0] frame_s;

    logic [W-1:0]        shadow_r [NUM_CH];
    logic [NUM_CH*W-1:0] dout_r;
    logic                frame_valid_r;
    logic                sync_err_r;
    logic [ERR_W-1:0]    err_count_r;

    tdm_chan_counter u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load_s),
        .inc       (cnt_inc_s),
        .cur_ch    (cur_ch_s),
        .last_slot (last_slot_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: only a sync beat leaves HUNT; LOCKED is held until reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            HUNT: begin
                if (din_valid && din_sync) begin
                    next_state_s = LOCKED;
                end else begin
                    next_state_s = HUNT;
                end
            end
            LOCKED:  next_state_s = LOCKED;
            default: next_state_s = HUNT;
        endcase
    end

    // FSM outputs: per-beat datapath strobes.
    always_comb begin
        cnt_load_s   = 1'b0;
        cnt_inc_s    = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = {CH_W{1'b0}};
        frame_load_s = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            HUNT: begin
                if (din_valid && din_sync) begin
                    cnt_load_s = 1'b1;
                    wr_en_s    = 1'b1;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            LOCKED: begin
                if (din_valid && din_sync) begin
                    cnt_load_s = 1'b1;
                    wr_en_s    = 1'b1;
                    err_s      = (cur_ch_s != {CH_W{1'b0}});
                end else if (din_valid) begin
                    cnt_inc_s    = 1'b1;
                    wr_en_s      = 1'b1;
                    wr_idx_s     = cur_ch_s;
                    frame_load_s = last_slot_s;
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    // Next frame image: channels 0..6 from shadow, channel 7 straight from din.
    always_comb begin
        frame_s = {(NUM_CH*W){1'b0}};
        for (int k = 0; k < NUM_CH - 1; k++) begin
            frame_s[ch_slice(unsigned'(k), unsigned'(W)) +: W] = shadow_r[k];
        end
        frame_s[ch_slice(unsigned'(NUM_CH - 1), unsigned'(W)) +: W] = din;
    end

    // Shadow buffer; entries persist across frames since each slot is rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= {W{1'b0}};
            end
        end else if (wr_en_s) begin
            shadow_r[wr_idx_s] <= din;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Frame output register and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r        <= {(NUM_CH*W){1'b0}};
            frame_valid_r <= 1'b0;
        end else if (frame_load_s) begin
            dout_r        <= frame_s;
            frame_valid_r <= 1'b1;
        end else begin
            dout_r        <= dout_r;
            frame_valid_r <= 1'b0;
        end
    end

    // Mid-frame sync error pulse and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_r  <= 1'b0;
            err_count_r <= {ERR_W{1'b0}};
        end else if (err_s) begin
            sync_err_r <= 1'b1;
            if (err_count_r != {ERR_W{1'b1}}) begin
                err_count_r <= err_count_r + ERR_W'(1);
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            sync_err_r  <= 1'b0;
            err_count_r <= err_count_r;
        end
    end

    assign dout        = dout_r;
    assign frame_valid = frame_valid_r;
    assign locked      = (state_r == LOCKED);
    assign cur_ch      = cur_ch_s;
    assign sync_err    = sync_err_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_demux_8_tdm.sv
// Directed self-checking bench for demux_8_tdm (W=1, ERR_W=8).
module tb_demux_8_tdm;

    localparam int W     = 1;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             din_sync;
    logic [8*W-1:0]   dout;
    logic             frame_valid;
    logic             locked;
    logic [2:0]       cur_ch;
    logic             sync_err;
    logic [ERR_W-1:0] err_count;

    int n_checks;
    int n_errors;

    int          cyc;
    int          fv_total;
    int          se_total;
    int          fv_last_cyc;
    int          fv_prev_cyc;
    logic [7:0]  fv_last_dout;
    logic [7:0]  fv_prev_dout;

    demux_8_tdm #(.W(W), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .locked      (locked),
        .cur_ch      (cur_ch),
        .sync_err    (sync_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts and timestamps frame_valid / sync_err pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_valid) begin
            fv_total     <= fv_total + 1;
            fv_prev_cyc  <= fv_last_cyc;
            fv_last_cyc  <= cyc;
            fv_prev_dout <= fv_last_dout;
            fv_last_dout <= dout;
        end
        if (sync_err) begin
            se_total <= se_total + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic d, input logic s);
        @(negedge clk);
        din       = d;
        din_valid = 1'b1;
        din_sync  = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din_sync  = 1'b0;
            din       = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input logic with_sync);
        for (int i = 0; i < 8; i++) begin
            send(v[i], (i == 0) ? with_sync : 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_sync  = 1'b0;
        din       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int fv0;
        int se0;
        n_checks  = 0;
        n_errors  = 0;
        cyc = 0; fv_total = 0; se_total = 0;
        fv_last_cyc = 0; fv_prev_cyc = 0;
        fv_last_dout = 8'h00; fv_prev_dout = 8'h00;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        din_sync  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_val("rst_dout", {24'd0, dout}, 32'h0);
        check_val("rst_outs", {26'd0, frame_valid, locked, cur_ch, sync_err}, 32'h0);
        check_val("rst_errcnt", {24'd0, err_count}, 32'h0);
        rst_n = 1'b1;

        // Aligned frame ch0..7 = 1,0,1,1,0,0,1,0
        send_frame(8'h4D, 1'b1);
        idle(1);
        check_val("t1_fv_hi", {31'd0, frame_valid}, 32'd1);
        check_val("t1_dout", {24'd0, dout}, 32'h4D);
        check_val("t1_locked", {31'd0, locked}, 32'd1);
        check_val("t1_cur_ch", {29'd0, cur_ch}, 32'd0);
        idle(1);
        check_val("t1_fv_lo", {31'd0, frame_valid}, 32'd0);
        idle(1);

        // Gapped valid: same samples, idle cycles between beats
        fv0 = fv_total;
        for (int i = 0; i < 8; i++) begin
            send(((8'h4D >> i) & 8'h01) != 8'h00, (i == 0));
            idle(1);
            if (i == 2) begin
                check_val("t2_hold_a", {29'd0, cur_ch}, 32'd3);
                idle(1);
                check_val("t2_hold_b", {29'd0, cur_ch}, 32'd3);
            end
        end
        idle(2);
        check_val("t2_dout", {24'd0, dout}, 32'h4D);
        check_val("t2_fv_once", fv_total - fv0, 32'd1);

        // HUNT discard after a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
        idle(1);
        check_val("t3_hunt_lock", {31'd0, locked}, 32'd0);
        check_val("t3_hunt_ch", {29'd0, cur_ch}, 32'd0);
        send(1'b1, 1'b1);
        check_val("t3_lock_pre", {31'd0, locked}, 32'd0);
        idle(1);
        check_val("t3_lock_post", {31'd0, locked}, 32'd1);
        check_val("t3_ch_post", {29'd0, cur_ch}, 32'd1);
        for (int i = 1; i < 8; i++) send(((8'hA5 >> i) & 8'h01) != 8'h00, 1'b0);
        idle(1);
        check_val("t3_fv", {31'd0, frame_valid}, 32'd1);
        check_val("t3_dout", {24'd0, dout}, 32'hA5);
        idle(1);

        // Mid-frame sync drops the partial frame
        fv0 = fv_total;
        se0 = se_total;
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        send_frame(8'h3C, 1'b1);
        idle(2);
        check_val("t4_fv_cnt", fv_total - fv0, 32'd1);
        check_val("t4_se_cnt", se_total - se0, 32'd1);
        check_val("t4_errcnt", {24'd0, err_count}, 32'd1);
        check_val("t4_dout", {24'd0, dout}, 32'h3C);
        check_val("t4_se_lo", {31'd0, sync_err}, 32'd0);

        // Free-run wrap: second frame without sync
        fv0 = fv_total;
        se0 = se_total;
        send_frame(8'h0F, 1'b1);
        send_frame(8'hF0, 1'b0);
        idle(2);
        check_val("t5_fv_cnt", fv_total - fv0, 32'd2);
        check_val("t5_spacing", fv_last_cyc - fv_prev_cyc, 32'd8);
        check_val("t5_first", {24'd0, fv_prev_dout}, 32'h0F);
        check_val("t5_dout", {24'd0, dout}, 32'hF0);
        check_val("t5_cur_ch", {29'd0, cur_ch}, 32'd0);
        check_val("t5_no_err", se_total - se0, 32'd0);

        // Saturation: 300 mid-frame syncs on top of the existing error
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 1'b0);
            send(1'b0, 1'b1);
            if (i == 99) begin
                idle(1);
                check_val("t6_mid", {24'd0, err_count}, 32'd101);
            end
        end
        idle(1);
        check_val("t6_sat", {24'd0, err_count}, 32'd255);

        // Reset mid-frame
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        #1;
        check_val("t6_rst_dout", {24'd0, dout}, 32'h0);
        check_val("t6_rst_outs", {26'd0, frame_valid, locked, cur_ch, sync_err}, 32'h0);
        check_val("t6_rst_err", {24'd0, err_count}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fv0 = fv_total;
        send_frame(8'hFF, 1'b0);
        idle(2);
        check_val("t6_nosync_lock", {31'd0, locked}, 32'd0);
        check_val("t6_nosync_fv", fv_total - fv0, 32'd0);
        check_val("t6_nosync_dout", {24'd0, dout}, 32'h0);
        send_frame(8'h5A, 1'b1);
        idle(1);
        check_val("t6_resync", {24'd0, dout}, 32'h5A);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
